// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM compare block:
// FSM encoding and the duty clamp helper.
package pwm_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  function automatic logic [31:0] clamp_duty(
    input logic [31:0] d,
    input logic [31:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// Duty-value valid/ready channel into pwm_compare.
// Master supplies the duty, slave is the PWM block.
interface pwm_compare_if #(
  parameter int unsigned bits = 4
);

  logic [bits:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/pwm_compare_duty_shadow.sv
// Duty handshake, clamp, shadow (pending) register
// and the committed duty with its boundary bypass.
module duty_shadow
  import pwm_pkg::*;
#(
  parameter int unsigned bits = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          is_run,
  input  logic          boundary,
  input  logic [bits:0] duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic [bits:0] duty_eff
);

  localparam logic [31:0] MAXD = 32'(1) << bits;

  logic          pend_q, pend_d;
  logic [bits:0] pval_q, pval_d;
  logic [bits:0] act_q, act_d;
  logic [bits:0] din_c;
  logic          xfer;
  logic          commit;

  assign duty_ready = !pend_q;
  assign xfer       = duty_valid && !pend_q;
  assign commit     = boundary && pend_q;
  assign din_c      = (bits+1)'(clamp_duty(32'(duty_in), MAXD));
  assign duty_eff   = commit ? pval_q : act_q;

  // A value taken on the RUN-exit boundary is still
  // pending in IDLE; it drains at the next wrap.
  always_comb begin
    pend_d = pend_q;
    pval_d = pval_q;
    act_d  = act_q;
    if (commit) begin
      act_d  = pval_q;
      pend_d = 1'b0;
    end
    if (xfer) begin
      if (is_run) begin
        pend_d = 1'b1;
        pval_d = din_c;
      end else begin
        act_d = din_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      pval_q <= '0;
      act_q  <= '0;
    end else begin
      pend_q <= pend_d;
      pval_q <= pval_d;
      act_q  <= act_d;
    end
  end

endmodule

// File: rtl/pwm_compare.sv
// Registered PWM from a free-running count, with
// period-aligned duty updates and enable sequencing.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int unsigned bits = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [bits-1:0] count,
  input  logic            enable,
  pwm_compare_if.slave    duty,
  output logic            pwm,
  output logic            period_tick,
  output logic            active
);

  logic [1:0]    state_q, state_d;
  logic          pwm_q, pwm_d;
  logic          tick_q, tick_d;
  logic          boundary;
  logic          last;
  logic          is_run;
  logic [bits:0] duty_eff;

  assign boundary = (count == '0);
  assign last     = (count == '1);
  assign is_run   = (state_q == RUN);

  duty_shadow #(
    .bits (bits)
  ) u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .is_run     (is_run),
    .boundary   (boundary),
    .duty_in    (duty.duty_in),
    .duty_valid (duty.duty_valid),
    .duty_ready (duty.duty_ready),
    .duty_eff   (duty_eff)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = SYNC;
      SYNC: begin
        if (!enable)       state_d = IDLE;
        else if (boundary) state_d = RUN;
      end
      RUN:  if (boundary && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Qualify by the state that owns this count, so the
  // wrap that ends a disabled period stays low.
  always_comb begin
    pwm_d  = (state_d == RUN) &&
             ({1'b0, count} < duty_eff);
    tick_d = is_run && last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;
  assign active      = is_run;

endmodule
